register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per entry; multiple of 8, 8..64.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, 2..64; IDX = $clog2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = entry 0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 0; 1 = same-cycle write data forwarded to reads.
REQ-005 SHALL have parameter READ_LATENCY, default 0; 0 = combinational read, 1 = registered read.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports read_index_a and read_index_b, input, IDX each, read addresses.
REQ-009 SHALL have ports read_data_a and read_data_b, output, WIDTH each, read results.
REQ-010 SHALL have ports write_enable_a and write_enable_b, input, 1 each, write requests.
REQ-011 SHALL have ports write_index_a and write_index_b, input, IDX each, write addresses.
REQ-012 SHALL have ports write_data_a and write_data_b, input, WIDTH each, write data.
REQ-013 SHALL have ports write_strobe_a and write_strobe_b, input, WIDTH/8 each, byte enables.

Function
REQ-014 SHALL, on posedge with reset=0 and write_enable_x=1, update only the bytes of entry write_index_x whose write_strobe_x bit is 1.
REQ-015 SHALL leave all entries unchanged when both write enables are 0 or all enabled strobes are 0.
REQ-016 SHALL, when both ports write the same entry, apply port A bytes first, then port B bytes; B wins on overlapping strobes, each port's unique bytes are kept.
REQ-017 SHALL, with ZERO_REG=1, ignore writes to entry 0 and return 0 for every read of entry 0, including bypassed reads.
REQ-018 SHALL, with READ_LATENCY=0 and BYPASS=0, drive read_data_x combinationally from the stored entry read_index_x.
REQ-019 SHALL, with BYPASS=1, return for each byte of read_data_x the value the entry will hold after the current edge, including the B-over-A merge.
REQ-020 SHALL, with READ_LATENCY=1, register read_data_x on posedge from the value the REQ-018/REQ-019 path produces in that cycle; latency exactly one cycle.
REQ-021 SHALL allow both read ports to address any entry at the same time, including the same entry, with no conflict.
REQ-022 SHALL produce no X on read_data_x after the first reset edge, for any legal index.

Reset
REQ-023 SHALL clear every entry to 0 on a posedge with reset=1; writes in that cycle are discarded.
REQ-024 SHALL force read_data_a and read_data_b to 0 while reset=1, for any READ_LATENCY.
REQ-025 SHALL clear the READ_LATENCY=1 output registers to 0 on a reset edge.
REQ-026 SHALL, on reset asserted mid-sequence, discard any pending registered read; the first read after reset returns 0 or newly written data.

Structure
REQ-027 SHALL take default WIDTH, DEPTH and the mode parameter constants from shared package register_file_pkg.
REQ-028 SHALL instantiate one sub-module, register_file_read_port, once per read port; it holds the index mux, the bypass merge, zero-reg masking and the optional output register.
REQ-029 SHALL keep the storage array and the byte-strobe write merge in register_file_mp.

Verification
REQ-030 Bench SHALL cover: reset, then write A idx2=16'hBEEF strobe 2'b11, then read a=2 -> 16'hBEEF (latency 0 and 1).
REQ-031 Bench SHALL cover: entry 1=16'h1234; write A idx1 data 16'hAB00 strobe 2'b10 -> read 1 = 16'hAB34.
REQ-032 Bench SHALL cover: same cycle, A idx3=16'h1111 strobe 2'b11 and B idx3=16'h2222 strobe 2'b01 -> read 3 = 16'h1122.
REQ-033 Bench SHALL cover: BYPASS=1, write idx0=16'h5A5A while read_a=0 -> read_data_a=16'h5A5A in the same cycle; with ZERO_REG=1 -> 0.
REQ-034 Bench SHALL cover: all entries nonzero, reset for one cycle -> all reads 0, and 0 while reset is high.
REQ-035 Bench SHALL cover: 1000 random cycles (1% reset, random strobes, both ports) against a shadow model, zero mismatches, for DEPTH=8, WIDTH=32 and the defaults.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared defaults for the multi-port register file and its read ports.
package register_file_pkg;

    localparam int unsigned DEFAULT_WIDTH        = 16;
    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam bit          DEFAULT_ZERO_REG     = 1'b0;
    localparam bit          DEFAULT_BYPASS       = 1'b0;
    localparam int unsigned DEFAULT_READ_LATENCY = 0;

endpackage

// File: rtl/register_file_read_port.sv
// One read port: index mux, same-cycle write forwarding, entry-0 masking and
// an optional output register.
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter bit          ZERO_REG     = DEFAULT_ZERO_REG,
    parameter bit          BYPASS       = DEFAULT_BYPASS,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int unsigned IDX          = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [IDX-1:0]         i_index,
    input  logic [DEPTH*WIDTH-1:0] i_mem,
    input  logic                   i_we_a,
    input  logic [IDX-1:0]         i_wi_a,
    input  logic [WIDTH-1:0]       i_wd_a,
    input  logic [WIDTH/8-1:0]     i_ws_a,
    input  logic                   i_we_b,
    input  logic [IDX-1:0]         i_wi_b,
    input  logic [WIDTH-1:0]       i_wd_b,
    input  logic [WIDTH/8-1:0]     i_ws_b,
    output logic [WIDTH-1:0]       o_data
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0] w_value;
    logic             w_unused;

    // Ports may be unused depending on BYPASS / READ_LATENCY.
    assign w_unused = ^{i_clk, i_we_a, i_wi_a, i_wd_a, i_ws_a, i_we_b, i_wi_b, i_wd_b, i_ws_b};

    always_comb begin
        w_value = i_mem[int'(i_index) * WIDTH +: WIDTH];
        if (BYPASS) begin
            // A first, then B, so B wins on overlapping bytes.
            for (int b = 0; b < NB; b++) begin
                if (i_we_a && i_wi_a == i_index && i_ws_a[b]) begin
                    w_value[b*8 +: 8] = i_wd_a[b*8 +: 8];
                end
                if (i_we_b && i_wi_b == i_index && i_ws_b[b]) begin
                    w_value[b*8 +: 8] = i_wd_b[b*8 +: 8];
                end
            end
        end
        if ((ZERO_REG && i_index == '0) || i_reset) begin
            w_value = '0;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_reg
            logic [WIDTH-1:0] r_data;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_data <= '0;
                end else begin
                    r_data <= w_value;
                end
            end

            assign o_data = i_reset ? '0 : r_data;
        end else begin : g_comb
            assign o_data = w_value;
        end
    endgenerate

endmodule

// File: rtl/register_file_mp.sv
// Register file with two byte-strobed write ports and two independent read ports.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int unsigned WIDTH        = DEFAULT_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter bit          ZERO_REG     = DEFAULT_ZERO_REG,
    parameter bit          BYPASS       = DEFAULT_BYPASS,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
    localparam int unsigned IDX         = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX-1:0]     read_index_a,
    input  logic [IDX-1:0]     read_index_b,
    output logic [WIDTH-1:0]   read_data_a,
    output logic [WIDTH-1:0]   read_data_b,
    input  logic               write_enable_a,
    input  logic               write_enable_b,
    input  logic [IDX-1:0]     write_index_a,
    input  logic [IDX-1:0]     write_index_b,
    input  logic [WIDTH-1:0]   write_data_a,
    input  logic [WIDTH-1:0]   write_data_b,
    input  logic [WIDTH/8-1:0] write_strobe_a,
    input  logic [WIDTH/8-1:0] write_strobe_b
);

    localparam int unsigned NB = WIDTH / 8;

    logic [WIDTH-1:0]       r_mem      [DEPTH];
    logic [WIDTH-1:0]       w_mem_next [DEPTH];
    logic [DEPTH*WIDTH-1:0] w_mem_flat;

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_mem_next[e] = r_mem[e];
            for (int b = 0; b < NB; b++) begin
                if (write_enable_a && write_index_a == IDX'(e) && write_strobe_a[b]) begin
                    w_mem_next[e][b*8 +: 8] = write_data_a[b*8 +: 8];
                end
                if (write_enable_b && write_index_b == IDX'(e) && write_strobe_b[b]) begin
                    w_mem_next[e][b*8 +: 8] = write_data_b[b*8 +: 8];
                end
            end
            if (ZERO_REG && e == 0) begin
                w_mem_next[e] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (reset) begin
                r_mem[e] <= '0;
            end else begin
                r_mem[e] <= w_mem_next[e];
            end
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_flat
        assign w_mem_flat[e*WIDTH +: WIDTH] = r_mem[e];
    end

    register_file_read_port #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .ZERO_REG    (ZERO_REG),
        .BYPASS      (BYPASS),
        .READ_LATENCY(READ_LATENCY),
        .IDX         (IDX)
    ) u_read_a (
        .i_clk  (clk),
        .i_reset(reset),
        .i_index(read_index_a),
        .i_mem  (w_mem_flat),
        .i_we_a (write_enable_a),
        .i_wi_a (write_index_a),
        .i_wd_a (write_data_a),
        .i_ws_a (write_strobe_a),
        .i_we_b (write_enable_b),
        .i_wi_b (write_index_b),
        .i_wd_b (write_data_b),
        .i_ws_b (write_strobe_b),
        .o_data (read_data_a)
    );

    register_file_read_port #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .ZERO_REG    (ZERO_REG),
        .BYPASS      (BYPASS),
        .READ_LATENCY(READ_LATENCY),
        .IDX         (IDX)
    ) u_read_b (
        .i_clk  (clk),
        .i_reset(reset),
        .i_index(read_index_b),
        .i_mem  (w_mem_flat),
        .i_we_a (write_enable_a),
        .i_wi_a (write_index_a),
        .i_wd_a (write_data_a),
        .i_ws_a (write_strobe_a),
        .i_we_b (write_enable_b),
        .i_wi_b (write_index_b),
        .i_wd_b (write_data_b),
        .i_ws_b (write_strobe_b),
        .o_data (read_data_b)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: six configurations share one stimulus stream; expected reads
// are queued by the stimulus and checked by a monitor on the falling edge.
module tb_register_file_mp;

    localparam int NI = 6;

    // Per-instance configuration, index order matches the instances below.
    int cfg_w   [NI] = '{16, 16, 16, 16, 32, 16};
    int cfg_d   [NI] = '{4, 4, 4, 4, 8, 4};
    int cfg_lat [NI] = '{0, 1, 0, 0, 1, 1};
    int cfg_byp [NI] = '{0, 0, 1, 1, 1, 1};
    int cfg_zr  [NI] = '{0, 0, 0, 1, 0, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  ria, rib, wia, wib;
    logic        wea, web;
    logic [31:0] wda, wdb;
    logic [3:0]  wsa, wsb;

    logic [15:0] d16a [NI];
    logic [15:0] d16b [NI];
    logic [31:0] d32a, d32b;

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] exp;
        int          phase;
    } exp_t;

    exp_t        q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          phase   = 0;
    logic [31:0] m_mem [NI][8];
    logic [31:0] m_rq  [NI][2];

    register_file_mp u_dut0 (
        .clk(clk), .reset(reset),
        .read_index_a(ria[1:0]), .read_index_b(rib[1:0]),
        .read_data_a(d16a[0]), .read_data_b(d16b[0]),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia[1:0]), .write_index_b(wib[1:0]),
        .write_data_a(wda[15:0]), .write_data_b(wdb[15:0]),
        .write_strobe_a(wsa[1:0]), .write_strobe_b(wsb[1:0])
    );

    register_file_mp #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .read_index_a(ria[1:0]), .read_index_b(rib[1:0]),
        .read_data_a(d16a[1]), .read_data_b(d16b[1]),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia[1:0]), .write_index_b(wib[1:0]),
        .write_data_a(wda[15:0]), .write_data_b(wdb[15:0]),
        .write_strobe_a(wsa[1:0]), .write_strobe_b(wsb[1:0])
    );

    register_file_mp #(.BYPASS(1'b1)) u_dut2 (
        .clk(clk), .reset(reset),
        .read_index_a(ria[1:0]), .read_index_b(rib[1:0]),
        .read_data_a(d16a[2]), .read_data_b(d16b[2]),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia[1:0]), .write_index_b(wib[1:0]),
        .write_data_a(wda[15:0]), .write_data_b(wdb[15:0]),
        .write_strobe_a(wsa[1:0]), .write_strobe_b(wsb[1:0])
    );

    register_file_mp #(.BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut3 (
        .clk(clk), .reset(reset),
        .read_index_a(ria[1:0]), .read_index_b(rib[1:0]),
        .read_data_a(d16a[3]), .read_data_b(d16b[3]),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia[1:0]), .write_index_b(wib[1:0]),
        .write_data_a(wda[15:0]), .write_data_b(wdb[15:0]),
        .write_strobe_a(wsa[1:0]), .write_strobe_b(wsb[1:0])
    );

    register_file_mp #(.WIDTH(32), .DEPTH(8), .BYPASS(1'b1), .READ_LATENCY(1)) u_dut4 (
        .clk(clk), .reset(reset),
        .read_index_a(ria), .read_index_b(rib),
        .read_data_a(d32a), .read_data_b(d32b),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia), .write_index_b(wib),
        .write_data_a(wda), .write_data_b(wdb),
        .write_strobe_a(wsa), .write_strobe_b(wsb)
    );

    register_file_mp #(.BYPASS(1'b1), .ZERO_REG(1'b1), .READ_LATENCY(1)) u_dut5 (
        .clk(clk), .reset(reset),
        .read_index_a(ria[1:0]), .read_index_b(rib[1:0]),
        .read_data_a(d16a[5]), .read_data_b(d16b[5]),
        .write_enable_a(wea), .write_enable_b(web),
        .write_index_a(wia[1:0]), .write_index_b(wib[1:0]),
        .write_data_a(wda[15:0]), .write_data_b(wdb[15:0]),
        .write_strobe_a(wsa[1:0]), .write_strobe_b(wsb[1:0])
    );

    assign d16a[4] = 16'h0;
    assign d16b[4] = 16'h0;

    function automatic logic [31:0] actual(input int inst, input int port);
        if (inst == 4) return (port == 0) ? d32a : d32b;
        return (port == 0) ? {16'h0, d16a[inst]} : {16'h0, d16b[inst]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s, input int nb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < nb; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Monitor: read outputs are always presented, so drain this cycle's entries.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_act = actual(mon_e.inst, mon_e.port);
            n_total++;
            if (mon_act === mon_e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL rd inst%0d port%0d phase%0d: got %h expected %h",
                         mon_e.inst, mon_e.port, mon_e.phase, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $finish;
    end

    task automatic hand(input int inst, input int port, input logic [31:0] v);
        q.push_back('{inst, port, v, phase});
    endtask

    // Push the shadow-model expectation for every instance, advance the model,
    // then move to just after the next rising edge.
    task automatic step();
        for (int i = 0; i < NI; i++) begin
            int          nb;
            logic [2:0]  m, ri, wa, wb;
            logic [31:0] v;
            nb = cfg_w[i] / 8;
            m  = 3'(cfg_d[i] - 1);
            wa = wia & m;
            wb = wib & m;
            for (int p = 0; p < 2; p++) begin
                ri = ((p == 0) ? ria : rib) & m;
                v  = m_mem[i][ri];
                if (cfg_byp[i] != 0) begin
                    if (wea && wa == ri) v = merge(v, wda, wsa, nb);
                    if (web && wb == ri) v = merge(v, wdb, wsb, nb);
                end
                if ((cfg_zr[i] != 0 && ri == 3'd0) || reset) v = 32'h0;
                q.push_back('{i, p, (cfg_lat[i] != 0) ? (reset ? 32'h0 : m_rq[i][p]) : v,
                              phase});
                m_rq[i][p] = v;
            end
            if (reset) begin
                for (int e = 0; e < 8; e++) m_mem[i][e] = 32'h0;
            end else begin
                if (wea && !(cfg_zr[i] != 0 && wa == 3'd0))
                    m_mem[i][wa] = merge(m_mem[i][wa], wda, wsa, nb);
                if (web && !(cfg_zr[i] != 0 && wb == 3'd0))
                    m_mem[i][wb] = merge(m_mem[i][wb], wdb, wsb, nb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; wea = 1'b0; web = 1'b0;
    endtask

    task automatic wr_a(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
        wea = 1'b1; wia = i; wda = d; wsa = s;
    endtask

    task automatic wr_b(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
        web = 1'b1; wib = i; wdb = d; wsb = s;
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b);
        ria = a; rib = b;
    endtask

    initial begin
        reset = 1'b1; wea = 1'b0; web = 1'b0;
        wia = '0; wib = '0; wda = '0; wdb = '0; wsa = '0; wsb = '0;
        rd(0, 1);
        @(posedge clk);
        #1;

        // Reset: outputs zero while reset is high
        phase = 1;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                n_total++;
                if (actual(i, p) === 32'h0) begin
                    n_pass++;
                end else begin
                    $display("FAIL reset inst%0d port%0d: got %h expected 0",
                             i, p, actual(i, p));
                end
            end
        end
        step();
        step();

        // Full write then read, combinational, bypassed and registered
        phase = 2;
        idle(); wr_a(2, 32'h0000_BEEF, 4'b0011); rd(2, 2);
        hand(2, 0, 32'h0000_BEEF);
        step();
        idle(); rd(2, 2);
        hand(0, 0, 32'h0000_BEEF); hand(0, 1, 32'h0000_BEEF); hand(4, 0, 32'h0000_BEEF);
        step();
        rd(2, 2);
        hand(1, 0, 32'h0000_BEEF);
        step();

        // Partial-byte write
        phase = 3;
        wr_a(1, 32'h0000_1234, 4'b0011); rd(1, 1);
        step();
        wr_a(1, 32'h0000_AB00, 4'b0010);
        step();
        idle(); rd(1, 0);
        hand(0, 0, 32'h0000_AB34); hand(4, 0, 32'h0000_AB34);
        step();
        rd(1, 1);
        hand(1, 0, 32'h0000_AB34);
        step();

        // Same-entry dual write, B wins on overlap
        phase = 4;
        wr_a(3, 32'h0000_1111, 4'b0011); wr_b(3, 32'h0000_2222, 4'b0001); rd(3, 3);
        hand(2, 0, 32'h0000_1122); hand(3, 1, 32'h0000_1122);
        step();
        idle(); rd(3, 3);
        hand(0, 0, 32'h0000_1122); hand(4, 1, 32'h0000_1122);
        step();

        // Bypass to entry 0, with and without zero register
        phase = 5;
        wr_a(0, 32'h0000_5A5A, 4'b0011); rd(0, 0);
        hand(2, 0, 32'h0000_5A5A); hand(3, 0, 32'h0);
        step();
        idle(); rd(0, 0);
        hand(0, 0, 32'h0000_5A5A); hand(5, 0, 32'h0);
        step();

        // Fill everything, then a one-cycle reset with a write that must be dropped
        phase = 6;
        for (int k = 0; k < 4; k++) begin
            wr_a(3'(k), 32'hC3C3_C3C0 + 32'(k), 4'hF);
            wr_b(3'(k + 4), 32'h5555_5550 + 32'(k), 4'hF);
            rd(3'(k), 3'(k + 4));
            step();
        end
        idle(); reset = 1'b1; wr_a(1, 32'hFFFF_FFFF, 4'hF); rd(1, 2);
        for (int i = 0; i < NI; i++) begin
            hand(i, 0, 32'h0);
            hand(i, 1, 32'h0);
        end
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            rd(3'(k), 3'(k + 4));
            hand(0, 0, 32'h0); hand(2, 1, 32'h0); hand(3, 0, 32'h0);
            if (k == 0) begin
                hand(1, 0, 32'h0); hand(4, 1, 32'h0);
            end
            step();
        end

        // Random traffic against the shadow model
        phase = 7;
        for (int n = 0; n < 1000; n++) begin
            reset = ($urandom_range(99) == 0);
            wea = 1'($urandom); web = 1'($urandom);
            wia = 3'($urandom); wib = 3'($urandom);
            wda = $urandom; wdb = $urandom;
            wsa = 4'($urandom); wsb = 4'($urandom);
            ria = 3'($urandom); rib = 3'($urandom);
            step();
        end

        idle();
        @(negedge clk);
        #1;
        if (q.size() != 0 || n_pass != n_total) begin
            $display("FAIL summary: %0d pending, %0d/%0d checks passed",
                     q.size(), n_pass, n_total);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
